// File: rtl/tx_symbol_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_sched_pkg
// Brief    : Symbol encodings, FSM state codes and compliance pattern table.
// Revision : 1.0
// ============================================================================
package tx_sched_pkg;

  localparam logic [7:0] K28_5    = 8'hBC;
  localparam logic [7:0] K28_0    = 8'h1C;
  localparam logic [7:0] D21_5    = 8'hB5;
  localparam logic [7:0] D10_2    = 8'h4A;
  localparam logic [7:0] IDLE_SYM = 8'h00;

  localparam logic [1:0] S_NORMAL   = 2'd0;
  localparam logic [1:0] S_SKP_COM  = 2'd1;
  localparam logic [1:0] S_SKP_BODY = 2'd2;
  localparam logic [1:0] S_COMP     = 2'd3;

  typedef struct packed {
    logic [7:0] data;
    logic       k;
  } sym_t;

  localparam sym_t [0:3] COMP_PATTERN = '{
    '{K28_5, 1'b1},
    '{D21_5, 1'b0},
    '{K28_5, 1'b1},
    '{D10_2, 1'b0}
  };

endpackage
`default_nettype wire

// File: rtl/tx_symbol_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_symbol_scheduler_if
// Brief    : Upstream handshake and encoder-side symbol bus of the scheduler.
// Revision : 1.0
// ============================================================================
interface tx_symbol_scheduler_if;

  logic [7:0] DATA_IN;
  logic       DATA_K_IN;
  logic       DATA_VALID;
  logic       DATA_READY;
  logic       COMPLIANCE_REQ;
  logic [7:0] oData;
  logic       TXDATAK;
  logic       TXCOMP;
  logic       SKP_ACTIVE;
  logic       COMP_ACTIVE;

  modport master (
    output DATA_IN, DATA_K_IN, DATA_VALID, COMPLIANCE_REQ,
    input  DATA_READY, oData, TXDATAK, TXCOMP, SKP_ACTIVE, COMP_ACTIVE
  );

  modport slave (
    input  DATA_IN, DATA_K_IN, DATA_VALID, COMPLIANCE_REQ,
    output DATA_READY, oData, TXDATAK, TXCOMP, SKP_ACTIVE, COMP_ACTIVE
  );

endinterface
`default_nettype wire

// File: rtl/tx_symbol_scheduler_counter.sv
`default_nettype none
// ============================================================================
// Module   : skp_interval_counter
// Brief    : Counts NORMAL-mode symbols and flags when an SKP set is due.
// Revision : 1.0
// ============================================================================
module skp_interval_counter #(
  parameter int CNT_W        = 11,
  parameter int SKP_INTERVAL = 1180
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic en,
  input  wire logic clr,
  output logic      due
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The scheduler stops counting while due is high, so r_cnt never passes it.
  assign due = (r_cnt == CNT_W'(SKP_INTERVAL));

endmodule
`default_nettype wire

// File: rtl/tx_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tx_symbol_scheduler
// Brief    : Selects data, idle, SKP ordered sets or compliance pattern for the encoder.
// Revision : 1.0
// ============================================================================
module tx_symbol_scheduler
  import tx_sched_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3,
  parameter int CNT_W        = 11
) (
  input  wire logic             INTERCLK,
  input  wire logic             Reset,
  tx_symbol_scheduler_if.slave  bus
);

  logic [1:0] r_state;
  logic [2:0] r_skp_idx;
  logic [1:0] r_phase;
  logic [7:0] r_data;
  logic       r_k;
  logic       r_txcomp;
  logic       r_skp_active;
  logic       r_comp_active;

  logic [1:0] w_nxt_state;
  logic [2:0] w_nxt_skp_idx;
  logic [1:0] w_nxt_phase;
  logic [7:0] w_nxt_data;
  logic       w_nxt_k;
  logic       w_nxt_txcomp;
  logic       w_nxt_skp;
  logic       w_nxt_comp;
  logic       w_cnt_en;
  logic       w_cnt_clr;
  logic       w_skp_due;
  logic       w_ready;

  skp_interval_counter #(
    .CNT_W        (CNT_W),
    .SKP_INTERVAL (SKP_INTERVAL)
  ) u_skp_cnt (
    .clk (INTERCLK),
    .rst (Reset),
    .en  (w_cnt_en),
    .clr (w_cnt_clr),
    .due (w_skp_due)
  );

  assign w_ready = !Reset && (r_state == S_NORMAL) && !w_skp_due && !bus.COMPLIANCE_REQ;
  assign bus.DATA_READY = w_ready;

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_skp_idx = r_skp_idx;
    w_nxt_phase   = r_phase;
    w_nxt_data    = IDLE_SYM;
    w_nxt_k       = 1'b0;
    w_nxt_txcomp  = 1'b0;
    w_nxt_skp     = 1'b0;
    w_nxt_comp    = 1'b0;
    w_cnt_en      = 1'b0;
    w_cnt_clr     = 1'b0;
    case (r_state)
      S_NORMAL: begin
        if (w_skp_due) begin
          w_nxt_data    = K28_5;
          w_nxt_k       = 1'b1;
          w_nxt_skp     = 1'b1;
          w_nxt_skp_idx = 3'd0;
          w_nxt_state   = S_SKP_BODY;
          w_cnt_clr     = 1'b1;
        end else if (bus.COMPLIANCE_REQ) begin
          w_nxt_data   = K28_5;
          w_nxt_k      = 1'b1;
          w_nxt_txcomp = 1'b1;
          w_nxt_comp   = 1'b1;
          w_nxt_phase  = 2'd1;
          w_nxt_state  = S_COMP;
        end else if (bus.DATA_VALID && w_ready) begin
          w_nxt_data = bus.DATA_IN;
          w_nxt_k    = bus.DATA_K_IN;
          w_cnt_en   = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      S_SKP_BODY: begin
        w_nxt_data    = K28_0;
        w_nxt_k       = 1'b1;
        w_nxt_skp     = 1'b1;
        w_nxt_skp_idx = r_skp_idx + 3'd1;
        if (r_skp_idx == 3'(SKP_LEN - 1)) begin
          w_nxt_state = S_NORMAL;
        end
      end
      S_COMP: begin
        w_nxt_data   = COMP_PATTERN[r_phase].data;
        w_nxt_k      = COMP_PATTERN[r_phase].k;
        w_nxt_txcomp = (r_phase == 2'd0);
        w_nxt_comp   = 1'b1;
        w_nxt_phase  = r_phase + 2'd1;
        // A pattern always completes; the request is only sampled on its last phase.
        if (r_phase == 2'd3 && !bus.COMPLIANCE_REQ) begin
          w_nxt_state = S_NORMAL;
          w_cnt_clr   = 1'b1;
        end
      end
      S_SKP_COM: begin
        w_nxt_state = S_NORMAL;
      end
      default: begin
        w_nxt_state = S_NORMAL;
      end
    endcase
  end

  always_ff @(posedge INTERCLK) begin
    if (Reset) begin
      r_state       <= S_NORMAL;
      r_skp_idx     <= 3'd0;
      r_phase       <= 2'd0;
      r_data        <= 8'h00;
      r_k           <= 1'b0;
      r_txcomp      <= 1'b0;
      r_skp_active  <= 1'b0;
      r_comp_active <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_skp_idx     <= w_nxt_skp_idx;
      r_phase       <= w_nxt_phase;
      r_data        <= w_nxt_data;
      r_k           <= w_nxt_k;
      r_txcomp      <= w_nxt_txcomp;
      r_skp_active  <= w_nxt_skp;
      r_comp_active <= w_nxt_comp;
    end
  end

  assign bus.oData       = r_data;
  assign bus.TXDATAK     = r_k;
  assign bus.TXCOMP      = r_txcomp;
  assign bus.SKP_ACTIVE  = r_skp_active;
  assign bus.COMP_ACTIVE = r_comp_active;

endmodule
`default_nettype wire

// File: tb/tb_tx_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_symbol_scheduler
// Brief    : Directed scoreboard bench for tx_symbol_scheduler (SKP_INTERVAL=16, SKP_LEN=3).
// Revision : 1.0
// ============================================================================
module tb_tx_symbol_scheduler;

  localparam int C_SKP_INTERVAL = 16;
  localparam int C_SKP_LEN      = 3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Expected output word: {oData, TXDATAK, TXCOMP, SKP_ACTIVE, COMP_ACTIVE}
  logic [11:0] exp_q[$];

  tx_symbol_scheduler_if bus();

  tx_symbol_scheduler #(
    .SKP_INTERVAL (C_SKP_INTERVAL),
    .SKP_LEN      (C_SKP_LEN),
    .CNT_W        (5)
  ) dut (
    .INTERCLK (clk),
    .Reset    (rst),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input string tag, input logic [7:0] d, input logic k, input logic tc,
                      input logic skp, input logic ca);
    logic [11:0] obs;
    logic [11:0] e;
    exp_q.push_back({d, k, tc, skp, ca});
    @(posedge clk);
    #1;
    obs = {bus.oData, bus.TXDATAK, bus.TXCOMP, bus.SKP_ACTIVE, bus.COMP_ACTIVE};
    e   = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    #1;
    checks++;
    assert (bus.DATA_READY === exp) else begin
      failures++;
      $error("FAIL %s DATA_READY observed=%b expected=%b", tag, bus.DATA_READY, exp);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic skp_set(input string tag);
    chk_ready({tag, "_rdy_com"}, 1'b0);
    step({tag, "_com"}, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < C_SKP_LEN; i++) begin
      chk_ready({tag, "_rdy_skp"}, 1'b0);
      step({tag, "_skp"}, 8'h1C, 1'b1, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic pattern(input string tag);
    step({tag, "_p0"}, 8'hBC, 1'b1, 1'b1, 1'b0, 1'b1);
    step({tag, "_p1"}, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b1);
    step({tag, "_p2"}, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1);
    step({tag, "_p3"}, 8'h4A, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] v;
    checks   = 0;
    failures = 0;
    rst                = 1'b1;
    bus.DATA_IN        = 8'h00;
    bus.DATA_K_IN      = 1'b0;
    bus.DATA_VALID     = 1'b0;
    bus.COMPLIANCE_REQ = 1'b0;

    // Reset state
    step("rst0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ready("rst_ready", 1'b0);
    step("rst1", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk_ready("post_rst_ready", 1'b1);

    // Idle with periodic SKP, 20-symbol period
    for (int r = 0; r < 2; r++) begin
      idle("t1_idle", C_SKP_INTERVAL);
      skp_set("t1");
    end

    // Data ramp with back-pressure around SKP sets
    v = 8'h00;
    bus.DATA_VALID = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < C_SKP_INTERVAL; i++) begin
        bus.DATA_IN = v;
        chk_ready("t2_rdy", 1'b1);
        step("t2_ramp", v, 1'b0, 1'b0, 1'b0, 1'b0);
        v = v + 8'd1;
      end
      bus.DATA_IN = v;
      skp_set("t2");
    end

    // Upstream K character passes through and counts toward the interval
    bus.DATA_IN   = 8'hBC;
    bus.DATA_K_IN = 1'b1;
    step("t3_kdata", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.DATA_VALID = 1'b0;
    bus.DATA_K_IN  = 1'b0;
    idle("t3_idle", C_SKP_INTERVAL - 1);
    skp_set("t3");

    // Single-cycle compliance request
    idle("t4_pre", 5);
    bus.COMPLIANCE_REQ = 1'b1;
    chk_ready("t4_rdy_req", 1'b0);
    step("t4_p0", 8'hBC, 1'b1, 1'b1, 1'b0, 1'b1);
    bus.COMPLIANCE_REQ = 1'b0;
    step("t4_p1", 8'hB5, 1'b0, 1'b0, 1'b0, 1'b1);
    step("t4_p2", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1);
    step("t4_p3", 8'h4A, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_ready("t4_rdy_after", 1'b1);
    idle("t4_idle", C_SKP_INTERVAL);
    skp_set("t4");

    // Request coincides with the SKP decision: set completes first, then patterns
    // repeat while the request is still high on each final phase.
    idle("t5_pre", C_SKP_INTERVAL);
    bus.COMPLIANCE_REQ = 1'b1;
    skp_set("t5");
    pattern("t5_a");
    pattern("t5_b");
    bus.COMPLIANCE_REQ = 1'b0;
    pattern("t5_c");
    chk_ready("t5_rdy_after", 1'b1);
    idle("t5_idle", 1);

    // Reset in the middle of an SKP set
    idle("t6_pre", C_SKP_INTERVAL - 1);
    step("t6_com", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0);
    step("t6_skp0", 8'h1C, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step("t6_rst_skp", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ready("t6_rdy_rst", 1'b0);
    rst = 1'b0;
    idle("t6_idle_a", C_SKP_INTERVAL);
    skp_set("t6a");

    // Reset in the middle of a compliance pattern
    bus.COMPLIANCE_REQ = 1'b1;
    step("t6_cp0", 8'hBC, 1'b1, 1'b1, 1'b0, 1'b1);
    bus.COMPLIANCE_REQ = 1'b0;
    step("t6_cp1", 8'hB5, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    step("t6_rst_comp", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ready("t6_rdy_rst2", 1'b0);
    rst = 1'b0;
    chk_ready("t6_rdy_rel", 1'b1);
    idle("t6_idle_b", C_SKP_INTERVAL);
    skp_set("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
